// File: rtl/pipelined_addsub.sv
// Pipelined signed add/subtract: the carry chain is split into CHUNK-bit slices, one per stage, with a global-stall handshake.
// Optional build macro ADDSUB_SAT_EN makes the result saturate on signed overflow.
module pipelined_addsub #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             cout
);

  localparam int unsigned STAGES = WIDTH / CHUNK;

  logic             advance;
  logic [WIDTH-1:0] bp;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign bp       = sub ? ~b : b;

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int unsigned RW = CHUNK * (k + 1);

    logic             vin;
    logic             sin;
    logic             cin;
    logic [CHUNK-1:0] sa;
    logic [CHUNK-1:0] sb;
    logic [CHUNK:0]   sum;
    logic [RW-1:0]    res_d;
    logic             vld_q;
    logic [RW-1:0]    res_q;

    // Slice operands and carry come from the ports for stage 0, otherwise from the previous stage.
    if (k == 0) begin : g_src
      assign vin   = in_valid;
      assign sin   = sub;
      assign cin   = sub ^ ci;
      assign sa    = a[CHUNK-1:0];
      assign sb    = bp[CHUNK-1:0];
      assign res_d = sum[CHUNK-1:0];
    end else begin : g_src
      assign vin   = g_stg[k-1].vld_q;
      assign sin   = g_stg[k-1].g_mid.sub_q;
      assign cin   = g_stg[k-1].g_mid.cy_q;
      assign sa    = g_stg[k-1].g_mid.ra_q[CHUNK-1:0];
      assign sb    = g_stg[k-1].g_mid.rb_q[CHUNK-1:0];
      assign res_d = {sum[CHUNK-1:0], g_stg[k-1].res_q};
    end

    assign sum = (CHUNK+1)'(sa) + (CHUNK+1)'(sb) + (CHUNK+1)'(cin);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
        res_q <= '0;
      end else if (advance) begin
        vld_q <= vin;
        res_q <= res_d;
      end
    end

    if (k < STAGES - 1) begin : g_mid
      localparam int unsigned UW = WIDTH - RW;

      logic [UW-1:0] ra_d;
      logic [UW-1:0] rb_d;
      logic [UW-1:0] ra_q;
      logic [UW-1:0] rb_q;
      logic          cy_q;
      logic          sub_q;

      // Unresolved upper slices ride along unmodified.
      if (k == 0) begin : g_rem
        assign ra_d = a[WIDTH-1:CHUNK];
        assign rb_d = bp[WIDTH-1:CHUNK];
      end else begin : g_rem
        assign ra_d = g_stg[k-1].g_mid.ra_q[UW+CHUNK-1:CHUNK];
        assign rb_d = g_stg[k-1].g_mid.rb_q[UW+CHUNK-1:CHUNK];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ra_q  <= '0;
          rb_q  <= '0;
          cy_q  <= 1'b0;
          sub_q <= 1'b0;
        end else if (advance) begin
          ra_q  <= ra_d;
          rb_q  <= rb_d;
          cy_q  <= sum[CHUNK];
          sub_q <= sin;
        end
      end
    end else begin : g_last
      logic cm;
      logic cout_q;
      logic ovf_q;

      // Carry into the MSB recovered from the sum bit and the MSB operands.
      assign cm = sum[CHUNK-1] ^ sa[CHUNK-1] ^ sb[CHUNK-1];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cout_q <= 1'b0;
          ovf_q  <= 1'b0;
        end else if (advance) begin
          cout_q <= sum[CHUNK] ^ sin;
          ovf_q  <= sum[CHUNK] ^ cm;
        end
      end

`ifdef ADDSUB_SAT_EN
      logic asign_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          asign_q <= 1'b0;
        end else if (advance) begin
          asign_q <= sa[CHUNK-1];
        end
      end
`endif
    end
  end

  assign out_valid = g_stg[STAGES-1].vld_q;
  assign overflow  = g_stg[STAGES-1].g_last.ovf_q;
  assign cout      = g_stg[STAGES-1].g_last.cout_q;

`ifdef ADDSUB_SAT_EN
  // On overflow the sign of a decides the direction of saturation.
  assign result = !g_stg[STAGES-1].g_last.ovf_q ? g_stg[STAGES-1].res_q :
                  g_stg[STAGES-1].g_last.asign_q ? {1'b1, {(WIDTH-1){1'b0}}} :
                                                   {1'b0, {(WIDTH-1){1'b1}}};
`else
  assign result = g_stg[STAGES-1].res_q;
`endif

endmodule

// File: tb/tb_pipelined_addsub.sv
// Scoreboard bench for pipelined_addsub (WIDTH=16, CHUNK=4): directed vectors, stalls, bubbles, reset flush.
module tb_pipelined_addsub;

  localparam int unsigned LAT = 4;
`ifdef ADDSUB_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        ci;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        overflow;
  logic        cout;

  typedef struct {
    logic [15:0] res;
    logic        ov;
    logic        co;
    int          acc;
    bit          lat;
  } exp_t;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic        sub;
    logic [15:0] r;
    logic [15:0] s;
    logic        ov;
    logic        co;
  } vec_t;

  exp_t exp_q[$];
  vec_t bp_vec[8];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  bit   chk_lat = 1'b1;

  pipelined_addsub #(.WIDTH(16), .CHUNK(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .ci        (ci),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .overflow  (overflow),
    .cout      (cout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Issue one transaction; the expectation is queued on the cycle it is accepted.
  task automatic send(input logic [15:0] ta, input logic [15:0] tb_op, input logic tci,
                      input logic tsub, input logic [15:0] er, input logic [15:0] es,
                      input logic eo, input logic ec);
    int   guard;
    exp_t e;
    guard    = 0;
    a        = ta;
    b        = tb_op;
    ci       = tci;
    sub      = tsub;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      guard++;
      @(negedge clk);
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 32'(in_ready), 32'd1);
    end else begin
      e.res = SAT ? es : er;
      e.ov  = eo;
      e.co  = ec;
      e.acc = cyc + 1;
      e.lat = chk_lat;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops on every output handshake and checks held outputs during stalls.
  initial begin
    logic        stall_prev;
    logic [17:0] held;
    exp_t        e;
    stall_prev = 1'b0;
    held       = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_prev = 1'b0;
      end else begin
        chk("in_ready_track", 32'(in_ready), 32'(!out_valid || out_ready));
        if (stall_prev)
          chk("stall_hold", {13'd0, out_valid, result, overflow, cout}, {13'd0, 1'b1, held});
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_out", 32'(result), 32'hDEAD_0000);
          end else begin
            e = exp_q.pop_front();
            chk("result", 32'(result), 32'(e.res));
            chk("overflow", 32'(overflow), 32'(e.ov));
            chk("cout", 32'(cout), 32'(e.co));
            if (e.lat) chk("latency", 32'(cyc - e.acc), 32'(LAT - 1));
          end
        end
        stall_prev = out_valid && !out_ready;
        held       = {result, overflow, cout};
      end
    end
  end

  initial begin
    int guard;
    bp_vec[0] = {16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 16'h2345, 1'b0, 1'b0};
    bp_vec[1] = {16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1};
    bp_vec[2] = {16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 16'h8000, 1'b1, 1'b1};
    bp_vec[3] = {16'h1000, 16'h0001, 1'b0, 1'b1, 16'h0FFF, 16'h0FFF, 1'b0, 1'b0};
    bp_vec[4] = {16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 16'h8000, 1'b1, 1'b0};
    bp_vec[5] = {16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 16'h7FFF, 1'b1, 1'b1};
    bp_vec[6] = {16'h00FF, 16'h0F0F, 1'b1, 1'b0, 16'h100F, 16'h100F, 1'b0, 1'b0};
    bp_vec[7] = {16'hABCD, 16'h1234, 1'b1, 1'b1, 16'h9998, 16'h9998, 1'b0, 1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a = '0; b = '0; ci = 1'b0; sub = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_flags", {30'd0, overflow, cout}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Directed arithmetic, no stall
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 16'h7FFF, 1'b1, 1'b0);
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
    send(16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0001, 16'h0001, 1'b0, 1'b0);
    send(16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
    send(16'h0000, 16'h8000, 1'b0, 1'b1, 16'h8000, 16'h7FFF, 1'b1, 1'b1);
    repeat (LAT + 2) idle();

    // Bubbles pass through uncollapsed
    send(16'h0010, 16'h0020, 1'b0, 1'b0, 16'h0030, 16'h0030, 1'b0, 1'b0);
    idle();
    send(16'h0100, 16'h0001, 1'b1, 1'b1, 16'h00FE, 16'h00FE, 1'b0, 1'b0);
    send(16'h4000, 16'h4000, 1'b0, 1'b0, 16'h8000, 16'h7FFF, 1'b1, 1'b0);
    idle();
    repeat (LAT + 2) idle();

    // Back-pressure with out_ready pattern 1,0,0,1
    chk_lat = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(bp_vec[i].a, bp_vec[i].b, bp_vec[i].ci, bp_vec[i].sub,
               bp_vec[i].r, bp_vec[i].s, bp_vec[i].ov, bp_vec[i].co);
      end
      begin
        for (int i = 0; i < 40; i++) begin
          out_ready = (i % 4 == 0) || (i % 4 == 3);
          @(posedge clk);
          #1;
        end
      end
    join
    out_ready = 1'b1;
    guard = 0;
    while (exp_q.size() != 0 && guard < 50) begin
      guard++;
      idle();
    end
    chk("drain_bp", 32'(exp_q.size()), 32'd0);

    // Reset mid-stream with transactions in flight
    chk_lat = 1'b1;
    send(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 16'h3333, 1'b0, 1'b0);
    send(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 16'h0002, 1'b0, 1'b0);
    send(16'h0003, 16'h0001, 1'b0, 1'b1, 16'h0002, 16'h0002, 1'b0, 1'b0);
    send(16'h0004, 16'h0004, 1'b0, 1'b0, 16'h0008, 16'h0008, 1'b0, 1'b0);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_result", 32'(result), 32'd0);
    chk("midrst_flags", {30'd0, overflow, cout}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (LAT + 4) @(posedge clk);
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_quiet", 32'(out_valid), 32'd0);

    // Pipeline still works after the flush
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
    repeat (LAT + 2) idle();
    chk("drain_final", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipelined_addsub.md
Name: pipelined_addsub

Overview:
- Parametrised, pipelined signed add/subtract unit for the lab datapath; successor to the fixed 16-bit adder/subtractor pair.
- Computes a+b+ci or a−b−ci in one unit, selected per transaction by a mode bit.
- Carry chain is split into CHUNK-bit slices, one slice per pipeline stage, with a valid/ready handshake on both sides.
- Flags: correct signed overflow, including b = most-negative value, and carry/borrow out.

Parameters:
- WIDTH, 16, operand/result width in bits; ≥ 2.
- CHUNK, 4, bits resolved per pipeline stage; must divide WIDTH exactly.
- STAGES (localparam) = WIDTH/CHUNK; this is the pipeline latency in cycles.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands present this cycle
- in_ready  output  1  unit accepts operands this cycle
- a  input  WIDTH  operand A, two's complement
- b  input  WIDTH  operand B, two's complement
- ci  input  1  carry-in (add) / borrow-in (sub)
- sub  input  1  0 = a+b+ci, 1 = a−b−ci
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- result  output  WIDTH  sum/difference, low WIDTH bits
- overflow  output  1  signed overflow of this result
- cout  output  1  carry-out (add) / borrow-out (sub)

Behaviour:
- Reset (async, rst_n=0):
  - All stage valid bits clear; out_valid=0, result=0, overflow=0, cout=0, immediately.
  - in_ready=1 from the first cycle after release.
  - Reset mid-operation discards all in-flight transactions; nothing partial is emitted.
- Arithmetic:
  - Operand B' = sub ? ~b : b.
  - LSB carry-in c0 = sub ? ~ci : ci, so sub computes a + ~b + 1 − ci.
  - cout = sub ? ~carry_msb_out : carry_msb_out.
  - overflow = carry into MSB XOR carry out of MSB, evaluated on the true addition a + B' + c0. Never ORed from a separate negation step.
  - Example: a=0, b=0x8000, sub=1 → result 0x8000, overflow=1.
- Pipeline:
  - Stage k (0..STAGES−1) adds slice k of a and B' plus the incoming carry.
  - It registers: valid, result bits [CHUNK*(k+1)−1:0], remaining upper operand slices, carry out of the slice, carry into the slice MSB (used for overflow in the last stage), and the sub flag.
  - Upper operand bits travel unmodified.
- Handshake (global stall):
  - advance = !out_valid || out_ready; in_ready = advance.
  - Input accepted when in_valid && in_ready.
  - On advance, every stage loads from its predecessor; stage 0 loads the accepted input, or a bubble (valid=0) if in_valid=0.
  - When advance=0, every stage register holds.
  - Output held stable while out_valid && !out_ready.
  - Bubbles are not collapsed.
- Timing:
  - Latency: a transaction accepted on edge N appears with out_valid=1 after edge N+STAGES−1, provided no stall occurs.
  - Throughput: one per cycle while out_ready=1.
- Boundary cases:
  - STAGES=1: single-cycle registered unit, same handshake.
  - Wrap-around: result is modulo 2^WIDTH; 0xFFFF+1 → 0x0000, cout=1, overflow=0.
  - Consumer stalls with pipeline full: in_ready=0, no input lost.
  - Stall released in the same cycle in_valid is asserted: input accepted.
  - ci in sub mode means borrow: a=5, b=3, ci=1 → 1.

Optional Feature:
- Macro: ADDSUB_SAT_EN.
- Defined:
  - On overflow, result saturates to 0x7FF…F if the true result is positive (a's sign = 0), or 0x800…0 if negative (a's sign = 1).
  - overflow still reports 1; cout unchanged.
  - Saturation is applied combinationally on the final-stage register output; latency unchanged.
- Undefined: result is the wrapped value; no saturation logic is instantiated.

Test Plan (WIDTH=16, CHUNK=4, latency 4):
- Reset: rst_n low mid-stream with 3 transactions in flight → out_valid=0 and result=0 immediately; nothing emitted after release; in_ready=1.
- Add, no stall: a=0x7FFF, b=0x0001, ci=0, sub=0 → 4 cycles later result=0x8000, overflow=1, cout=0. Then a=0xFFFF, b=0x0001 → result=0x0000, overflow=0, cout=1.
- Subtract and borrow:
  - a=0x0005, b=0x0003, ci=1, sub=1 → result=0x0001, overflow=0, cout=0.
  - a=0x0000, b=0x0001, ci=0, sub=1 → result=0xFFFF, cout=1.
- Most-negative subtrahend: a=0x0000, b=0x8000, sub=1 → result=0x8000, overflow=1. With ADDSUB_SAT_EN: result=0x7FFF.
- Back-pressure: stream 8 random operand sets with in_valid=1 and toggle out_ready 1,0,0,1,… → all 8 results emerge in order, match the reference model, and stay stable while stalled; in_ready tracks !out_valid || out_ready.
- Bubbles: in_valid pattern 1,0,1,1,0 with out_ready=1 → out_valid pattern is identical, delayed by 4 cycles.
